// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// The FIFO accepts bytes on wr_en while not full and reports overflow as a
// one-cycle pulse. The transmit FSM pops the head byte whenever the FIFO is
// non-empty and sends start/data/stop bits at CLKS_PER_BIT clocks per bit.
// All outputs, including the serial line, come straight from registers.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [7:0]                wr_data,
   output logic                      tx,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      busy,
   output logic                      tx_done,
   output logic                      ovf
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned CW        = AW + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          full_r;
   logic          empty_r;
   logic          ovf_r;

   // Transmitter state
   state_t        state_r;
   logic [15:0]   baud_r;
   logic [2:0]    bit_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          busy_r;
   logic          done_pend_r;
   logic          tx_done_r;

   // Combinational helpers
   logic          baud_last_s;
   logic          push_s;
   logic          pop_s;
   logic [7:0]    head_s;
   logic [CW-1:0] count_next_s;

   // Decode push/pop requests, the head byte and the next occupancy.
   always_comb begin
      baud_last_s  = (baud_r == BAUD_LAST);
      push_s       = wr_en & ~full_r;
      pop_s        = 1'b0;
      head_s       = mem_r[rd_ptr_r];
      count_next_s = count_r;
      if (!empty_r) begin
         if (state_r == IDLE) begin
            pop_s = 1'b1;
         end else if ((state_r == STOP) && baud_last_s) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Store accepted bytes; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO pointers, occupancy flags and the overflow pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         ovf_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == CNT_FULL);
         empty_r <= (count_next_s == {CW{1'b0}});
         ovf_r   <= wr_en & full_r;
      end
   end

   // Transmit FSM; tx is re-registered from the current state so the line
   // trails the FSM by one clock, and tx_done is delayed to match it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         baud_r      <= 16'd0;
         bit_r       <= 3'd0;
         shift_r     <= 8'd0;
         tx_r        <= 1'b1;
         busy_r      <= 1'b0;
         done_pend_r <= 1'b0;
         tx_done_r   <= 1'b0;
      end else begin
         done_pend_r <= 1'b0;
         tx_done_r   <= done_pend_r;

         case (state_r)
            IDLE:    tx_r <= 1'b1;
            START:   tx_r <= 1'b0;
            DATA:    tx_r <= shift_r[0];
            STOP:    tx_r <= 1'b1;
            default: tx_r <= 1'b1;
         endcase

         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  shift_r <= head_s;
                  baud_r  <= 16'd0;
                  bit_r   <= 3'd0;
                  state_r <= START;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            START: begin
               if (baud_last_s) begin
                  baud_r  <= 16'd0;
                  state_r <= DATA;
               end else begin
                  baud_r  <= baud_r + 16'd1;
               end
            end
            DATA: begin
               if (baud_last_s) begin
                  baud_r  <= 16'd0;
                  shift_r <= {1'b0, shift_r[7:1]};
                  if (bit_r == 3'd7) begin
                     state_r <= STOP;
                  end else begin
                     bit_r   <= bit_r + 3'd1;
                  end
               end else begin
                  baud_r  <= baud_r + 16'd1;
               end
            end
            STOP: begin
               if (baud_last_s) begin
                  baud_r      <= 16'd0;
                  done_pend_r <= 1'b1;
                  if (pop_s) begin
                     shift_r <= head_s;
                     bit_r   <= 3'd0;
                     state_r <= START;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  baud_r <= baud_r + 16'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               baud_r  <= 16'd0;
               bit_r   <= 3'd0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign tx      = tx_r;
   assign full    = full_r;
   assign empty   = empty_r;
   assign count   = count_r;
   assign busy    = busy_r;
   assign tx_done = tx_done_r;
   assign ovf     = ovf_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4.
// Written bytes go into a scoreboard queue; a line monitor decodes frames
// from tx and compares each received byte with the queue head.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       tx;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       busy;
   logic       tx_done;
   logic       ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frames_rx = 0;

   logic [7:0] sb [$];
   int         start_cyc [$];

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .tx(tx), .full(full), .empty(empty), .count(count),
      .busy(busy), .tx_done(tx_done), .ovf(ovf)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d, input bit accepted);
      wr_en   = 1'b1;
      wr_data = d;
      if (accepted) sb.push_back(d);
      tick;
      wr_en   = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int c = 0;
      while (frames_rx < n && c < budget) begin
         tick;
         c++;
      end
      chk("frames_received", frames_rx, n);
   endtask

   // Line monitor: samples tx at mid-bit on falling clock edges.
   initial begin
      bit         active = 1'b0;
      int         m_cnt = 0;
      logic [7:0] rx = 8'h00;
      logic [8:0] exp_b;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1'b1;
               m_cnt  = 0;
               start_cyc.push_back(cyc);
            end
         end else begin
            m_cnt++;
            if (m_cnt == 2) chk("start_bit", tx, 1'b0);
            if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0)
               rx[(m_cnt - 6) / 4] = tx;
            if (m_cnt == 38) begin
               chk("stop_bit", tx, 1'b1);
               exp_b = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
               chk("frame_byte", {1'b0, rx}, exp_b);
               frames_rx++;
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [7:0] b35 = 8'h35;
      logic       exp_tx;
      int         f0;

      // Reset, with a write attempt that must be ignored
      wr_en = 1'b1; wr_data = 8'hAA;
      repeat (3) tick;
      wr_en = 1'b0;
      chk("rst_tx", tx, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_count", count, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_done", tx_done, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      rst = 1'b0;
      repeat (3) tick;
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_empty", empty, 1'b1);

      // Single byte 0x35: exact cycle-by-cycle waveform and tx_done timing
      wr(8'h35, 1'b1);
      chk("w1_count", count, 3'd1);
      chk("w1_empty", empty, 1'b0);
      for (int k = 1; k <= 44; k++) begin
         tick;
         if (k == 1) exp_tx = 1'b1;
         else if (k <= 5) exp_tx = 1'b0;
         else if (k <= 37) exp_tx = b35[(k - 6) / 4];
         else exp_tx = 1'b1;
         chk($sformatf("f35_tx_k%0d", k), tx, exp_tx);
         chk($sformatf("f35_done_k%0d", k), tx_done, (k == 42) ? 1'b1 : 1'b0);
         if (k == 1) chk("f35_busy_start", busy, 1'b1);
      end
      chk("f35_busy_end", busy, 1'b0);
      chk("f35_frames", frames_rx, 1);

      // Back-to-back frames 0x35, 0x02 with no idle gap
      f0 = start_cyc.size();
      wr(8'h35, 1'b1);
      wr(8'h02, 1'b1);
      wait_frames(3, 150);
      chk("b2b_gap", start_cyc[f0 + 1] - start_cyc[f0], 40);
      repeat (10) tick;
      chk("b2b_idle_busy", busy, 1'b0);
      chk("b2b_idle_empty", empty, 1'b1);

      // Six writes: five accepted, sixth overflows and is dropped
      wr(8'h11, 1'b1); chk("ovf_w1", ovf, 1'b0);
      wr(8'h22, 1'b1); chk("ovf_w2", ovf, 1'b0);
      wr(8'h33, 1'b1); chk("ovf_w3", ovf, 1'b0);
      wr(8'h44, 1'b1); chk("ovf_w4", ovf, 1'b0);
      wr(8'h55, 1'b1); chk("ovf_w5", ovf, 1'b0);
      chk("full_set", full, 1'b1);
      chk("full_count", count, 3'd4);
      wr(8'h66, 1'b0);
      chk("ovf_pulse", ovf, 1'b1);
      chk("ovf_count", count, 3'd4);
      tick;
      chk("ovf_cleared", ovf, 1'b0);
      wait_frames(8, 260);
      repeat (60) tick;
      chk("ovf_no_extra_frame", frames_rx, 8);
      chk("ovf_drain_empty", empty, 1'b1);

      // Push on the pop edge at the end of stop keeps count at 2
      wr(8'hA1, 1'b1);
      wr(8'hB2, 1'b1);
      wr(8'hC4, 1'b1);
      chk("pp_count_q", count, 3'd2);
      repeat (38) tick;
      chk("pp_count_pre", count, 3'd2);
      wr(8'hD8, 1'b1);
      chk("pp_count_post", count, 3'd2);
      chk("pp_busy", busy, 1'b1);
      wait_frames(12, 220);
      repeat (10) tick;

      // Reset during data bit 3 aborts the frame and flushes the queue
      wr(8'hC3, 1'b1);
      wr(8'h5A, 1'b1);
      wr(8'h7E, 1'b1);
      repeat (17) tick;
      chk("mid_rst_bit3", tx, 1'b0);
      chk("mid_rst_count_pre", count, 3'd2);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      sb.delete();
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_count", count, 3'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_done", tx_done, 1'b0);

      // 100 idle cycles with no writes
      for (int k = 0; k < 100; k++) begin
         tick;
         chk("idle_tx", tx, 1'b1);
         chk("idle_busy", busy, 1'b0);
         chk("idle_empty", empty, 1'b1);
         chk("idle_done", tx_done, 1'b0);
      end
      chk("idle_frames", frames_rx, 12);

      // Recovery after reset
      wr(8'h96, 1'b1);
      wait_frames(13, 80);
      repeat (10) tick;
      chk("final_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
